stream_width_upsizer: RTL and testbench
=======================================

Name: stream_width_upsizer

Overview:
- Valid/ready stream stage that packs RATIO consecutive DATA_WIDTH-bit input beats into one DATA_WIDTH*RATIO-bit output beat.
- A beat marked in_last closes a packet early; the partially filled output carries a lane-keep mask.
- Sits directly downstream of the 32-bit pipeline register stage and feeds wide consumers such as the memory write path.
- Registered output, full input throughput while downstream is ready.

Parameters:
- DATA_WIDTH, 32, width of one input beat (one output lane).
- RATIO, 4, input beats per output beat. Legal range 2..16.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  DATA_WIDTH  upstream beat payload.
- in_last  input  1  beat is the final beat of its packet; qualified by in_valid.
- out_valid  output  1  wide beat valid.
- out_ready  input  1  downstream accepts the wide beat.
- out_data  output  DATA_WIDTH*RATIO  packed payload; lane k is bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_keep  output  RATIO  bit k set means lane k holds valid data.
- out_last  output  1  wide beat contains the packet's final input beat.

Behaviour:
- Reset: while reset is high at a rising edge, the following are cleared:
  - out_valid=0, out_data=0, out_keep=0, out_last=0.
  - Lane counter=0, accumulator and accumulator keep cleared.
  - in_ready reads 1 in the first cycle after reset deasserts.
- Reset mid-operation discards any partial accumulation and any held output beat. Nothing is emitted for them.
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = ~out_valid | out_ready. It is a pure function of registered state and out_ready, never of in_valid, in_data or in_last.
- Accumulator: internal DATA_WIDTH*RATIO register plus RATIO-bit keep and a lane counter (0..RATIO-1).
  - On in_fire, in_data is written to lane[cnt] and keep[cnt] is set.
- Completion: an in_fire completes a wide beat when cnt==RATIO-1 or in_last==1. On a completing in_fire:
  - out_data <= accumulator with the current beat merged in; unfilled lanes are forced to 0.
  - out_keep <= accumulated keep with bit cnt set.
  - out_last <= in_last; out_valid <= 1.
  - Accumulator, keep and cnt are cleared to 0.
- Non-completing in_fire: cnt <= cnt+1; output registers are untouched.
- Output hold: while out_valid & ~out_ready, out_data, out_keep and out_last are stable, and in_ready=0.
- out_fire without a completing in_fire in the same cycle: out_valid <= 0; the data registers may keep stale values.
- Simultaneous out_fire and completing in_fire: the new beat is loaded and out_valid stays 1, with no bubble.
- Latency: the completing input beat accepted at edge N produces out_valid=1 after edge N, i.e. one cycle.
- Throughput: one input beat per cycle while out_ready=1; one output beat per RATIO input cycles for full words.
- in_last on the first beat (cnt==0) yields out_keep with only bit 0 set, lanes 1..RATIO-1 zero, out_last=1.
- in_last on beat RATIO-1 yields a full keep and out_last=1; it is a single output beat, not an extra empty beat.
- in_last, in_data and in_valid are don't-care while in_valid=0 or in_ready=0; they are never sampled then.
- Counter wrap: cnt never exceeds RATIO-1; completion always returns it to 0.
- Upstream contract: once in_valid is asserted it stays asserted until in_fire. The block does not depend on this for correctness.
- Assertions for verification:
  - out_valid & ~out_ready implies the outputs are stable next cycle.
  - out_keep is never 0 while out_valid.
  - out_keep is contiguous from bit 0.

Test Plan:
- Full words: 8 beats 0x00000001..0x00000008, in_last on beat 8, out_ready=1 → two beats:
  - out_data=0x00000004_00000003_00000002_00000001, keep=0xF, last=0.
  - then 0x..08_07_06_05, keep=0xF, last=1.
  - Each beat appears one cycle after its 4th input.
- Short packet: 3 beats 0xA,0xB,0xC with in_last on 0xC → out_data=0x00000000_0000000C_0000000B_0000000A, keep=0x7, last=1.
- Single-beat packet: one beat 0x55 with in_last → keep=0x1, lanes 1..3 zero, last=1.
- Backpressure:
  - Hold out_ready=0 after the first completed word → in_ready=0 and the output stays stable for 5 cycles.
  - Release out_ready → the word is consumed, in_ready=1, and the following word is assembled correctly with no lost or duplicated beats.
- Back-to-back completion: out_ready=1 with continuous in_valid → out_valid stays 1 across the boundary where out_fire and the completing in_fire coincide; the output sequence matches the input order.
- Reset mid-accumulation: 2 beats accepted, reset high for 1 cycle, then 4 beats 0x1..0x4 → a single output 0x4_3_2_1 with keep=0xF; the pre-reset beats never appear.

Source files
------------

// File: rtl/stream_width_upsizer_if.sv
// Bundle for the width upsizer: a narrow valid/ready input stream and the
// wide packed output stream with lane keep and packet-last.
interface stream_width_upsizer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int RATIO      = 4
);
   logic                          in_valid;
   logic                          in_ready;
   logic [DATA_WIDTH-1:0]         in_data;
   logic                          in_last;
   logic                          out_valid;
   logic                          out_ready;
   logic [DATA_WIDTH*RATIO-1:0]   out_data;
   logic [RATIO-1:0]              out_keep;
   logic                          out_last;

   // Environment side: feeds the narrow stream and sinks the wide one.
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_keep, out_last
   );

   // Upsizer side.
   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_keep, out_last
   );
endinterface

// File: rtl/stream_width_upsizer.sv
// Packs RATIO narrow beats into one registered wide beat; in_last closes a
// packet early and out_keep marks which lanes of the wide beat are filled.
module stream_width_upsizer #(
   parameter int DATA_WIDTH = 32,
   parameter int RATIO      = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   stream_width_upsizer_if.slave  bus
);
   localparam int OUT_W = DATA_WIDTH * RATIO;
   localparam int CNT_W = $clog2(RATIO);

   logic [OUT_W-1:0]  acc_p0;
   logic [RATIO-1:0]  keep_p0;
   logic [CNT_W-1:0]  cnt_p0;

   logic [OUT_W-1:0]  out_data_p1;
   logic [RATIO-1:0]  out_keep_p1;
   logic              out_last_p1;
   logic              vld_p1;

   logic              in_fire;
   logic              out_fire;
   logic              complete;
   logic [OUT_W-1:0]  merged_data;
   logic [RATIO-1:0]  merged_keep;

   // Zero every lane whose keep bit is clear so partial beats never leak
   // stale accumulator contents.
   function automatic logic [OUT_W-1:0] mask_lanes(
      input logic [OUT_W-1:0] data,
      input logic [RATIO-1:0] keep
   );
      logic [OUT_W-1:0] m;
      m = '0;
      for (int k = 0; k < RATIO; k++) begin
         if (keep[k]) m[k*DATA_WIDTH +: DATA_WIDTH] = data[k*DATA_WIDTH +: DATA_WIDTH];
      end
      return m;
   endfunction

   assign bus.in_ready  = ~vld_p1 | bus.out_ready;
   assign bus.out_valid = vld_p1;
   assign bus.out_data  = out_data_p1;
   assign bus.out_keep  = out_keep_p1;
   assign bus.out_last  = out_last_p1;

   assign in_fire  = bus.in_valid & bus.in_ready;
   assign out_fire = vld_p1 & bus.out_ready;
   assign complete = bus.in_last | (cnt_p0 == CNT_W'(RATIO - 1));

   always_comb begin
      merged_data = acc_p0;
      merged_keep = keep_p0;
      for (int k = 0; k < RATIO; k++) begin
         if (cnt_p0 == CNT_W'(k)) begin
            merged_data[k*DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
            merged_keep[k]                          = 1'b1;
         end
      end
   end

   // p0 -> p1: accumulate narrow beats, load the wide output register on completion
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_p0      <= '0;
         keep_p0     <= '0;
         cnt_p0      <= '0;
         out_data_p1 <= '0;
         out_keep_p1 <= '0;
         out_last_p1 <= 1'b0;
         vld_p1      <= 1'b0;
      end else begin
         if (out_fire) vld_p1 <= 1'b0;
         if (in_fire) begin
            if (complete) begin
               out_data_p1 <= mask_lanes(merged_data, merged_keep);
               out_keep_p1 <= merged_keep;
               out_last_p1 <= bus.in_last;
               vld_p1      <= 1'b1;
               acc_p0      <= '0;
               keep_p0     <= '0;
               cnt_p0      <= '0;
            end else begin
               acc_p0  <= merged_data;
               keep_p0 <= merged_keep;
               cnt_p0  <= cnt_p0 + CNT_W'(1);
            end
         end
      end
   end

   a_hold_stable: assert property (@(posedge clk) disable iff (reset)
      (vld_p1 && !bus.out_ready) |=> (vld_p1 && $stable(out_data_p1)
                                      && $stable(out_keep_p1) && $stable(out_last_p1)));

   a_keep_nonzero: assert property (@(posedge clk) disable iff (reset)
      vld_p1 |-> (out_keep_p1 != '0));

   // A contiguous-from-bit-0 mask plus one is a power of two (or wraps to zero).
   a_keep_contig: assert property (@(posedge clk) disable iff (reset)
      vld_p1 |-> ((out_keep_p1 & (out_keep_p1 + RATIO'(1))) == '0));

   a_cnt_range: assert property (@(posedge clk) disable iff (reset)
      cnt_p0 <= CNT_W'(RATIO - 1));
endmodule

// File: tb/tb_stream_width_upsizer.sv
// Directed bench for stream_width_upsizer: full words, short and single-beat
// packets, backpressure, back-to-back completion and reset mid-packet.
module tb_stream_width_upsizer;
   logic clk = 1'b0;
   logic reset;

   stream_width_upsizer_if #(.DATA_WIDTH(32), .RATIO(4)) bus ();

   stream_width_upsizer #(.DATA_WIDTH(32), .RATIO(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic [127:0] cap_data[$];
   logic [3:0]   cap_keep[$];
   logic         cap_last[$];
   int           cap_cyc[$];
   int           fire_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Record every wide beat consumed downstream, with the cycle it was presented.
   always @(negedge clk) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         cap_data.push_back(bus.out_data);
         cap_keep.push_back(bus.out_keep);
         cap_last.push_back(bus.out_last);
         cap_cyc.push_back(cyc);
      end
   end

   task automatic clear_caps();
      cap_data.delete(); cap_keep.delete(); cap_last.delete();
      cap_cyc.delete();  fire_cyc.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drive_beat(input logic [31:0] d, input logic l);
      int  waited = 0;
      bit  done   = 0;
      bit  tout   = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = l;
      while (!done) begin
         @(negedge clk);
         if (bus.in_ready) done = 1;
         @(posedge clk); #1;
         if (!done) begin
            waited++;
            if (waited > 50) begin
               n_cmp++; n_fail++;
               $display("FAIL drive_timeout: beat %h not accepted within 50 cycles", d);
               done = 1; tout = 1;
            end
         end
      end
      if (!tout) fire_cyc.push_back(cyc);
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.out_data !== 128'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
      n_cmp++; if (bus.out_keep !== 4'h0) begin n_fail++; $display("FAIL reset_out_keep: got %h want 0", bus.out_keep); end
      n_cmp++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_full_words();
      clear_caps();
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) drive_beat(32'(i), i == 8);
      idle(3);
      n_cmp++;
      if (cap_data.size() != 2) begin
         n_fail++; $display("FAIL full_count: got %0d beats want 2", cap_data.size());
      end else begin
         n_cmp++; if (cap_data[0] !== 128'h00000004_00000003_00000002_00000001) begin n_fail++; $display("FAIL full_data0: got %h", cap_data[0]); end
         n_cmp++; if (cap_keep[0] !== 4'hF) begin n_fail++; $display("FAIL full_keep0: got %h want f", cap_keep[0]); end
         n_cmp++; if (cap_last[0] !== 1'b0) begin n_fail++; $display("FAIL full_last0: got %b want 0", cap_last[0]); end
         n_cmp++; if (cap_data[1] !== 128'h00000008_00000007_00000006_00000005) begin n_fail++; $display("FAIL full_data1: got %h", cap_data[1]); end
         n_cmp++; if (cap_keep[1] !== 4'hF) begin n_fail++; $display("FAIL full_keep1: got %h want f", cap_keep[1]); end
         n_cmp++; if (cap_last[1] !== 1'b1) begin n_fail++; $display("FAIL full_last1: got %b want 1", cap_last[1]); end
         n_cmp++; if (cap_cyc[0] !== fire_cyc[3]) begin n_fail++; $display("FAIL full_latency0: out at %0d want %0d", cap_cyc[0], fire_cyc[3]); end
         n_cmp++; if (cap_cyc[1] !== fire_cyc[7]) begin n_fail++; $display("FAIL full_latency1: out at %0d want %0d", cap_cyc[1], fire_cyc[7]); end
      end
   endtask

   task automatic test_short_packet();
      clear_caps();
      bus.out_ready = 1'b1;
      drive_beat(32'hA, 1'b0);
      drive_beat(32'hB, 1'b0);
      drive_beat(32'hC, 1'b1);
      idle(3);
      n_cmp++;
      if (cap_data.size() != 1) begin
         n_fail++; $display("FAIL short_count: got %0d beats want 1", cap_data.size());
      end else begin
         n_cmp++; if (cap_data[0] !== 128'h00000000_0000000C_0000000B_0000000A) begin n_fail++; $display("FAIL short_data: got %h", cap_data[0]); end
         n_cmp++; if (cap_keep[0] !== 4'h7) begin n_fail++; $display("FAIL short_keep: got %h want 7", cap_keep[0]); end
         n_cmp++; if (cap_last[0] !== 1'b1) begin n_fail++; $display("FAIL short_last: got %b want 1", cap_last[0]); end
      end
   endtask

   task automatic test_single_beat();
      clear_caps();
      bus.out_ready = 1'b1;
      drive_beat(32'h55, 1'b1);
      idle(3);
      n_cmp++;
      if (cap_data.size() != 1) begin
         n_fail++; $display("FAIL single_count: got %0d beats want 1", cap_data.size());
      end else begin
         n_cmp++; if (cap_data[0] !== 128'h00000000_00000000_00000000_00000055) begin n_fail++; $display("FAIL single_data: got %h", cap_data[0]); end
         n_cmp++; if (cap_keep[0] !== 4'h1) begin n_fail++; $display("FAIL single_keep: got %h want 1", cap_keep[0]); end
         n_cmp++; if (cap_last[0] !== 1'b1) begin n_fail++; $display("FAIL single_last: got %b want 1", cap_last[0]); end
      end
   endtask

   task automatic test_backpressure();
      clear_caps();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) drive_beat(32'h11 + 32'(i), 1'b0);
      // Offer the next beat while the wide word is stalled; it must not be taken.
      bus.in_valid = 1'b1; bus.in_data = 32'h21; bus.in_last = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.out_valid); end
         n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
         n_cmp++; if (bus.out_data !== 128'h00000014_00000013_00000012_00000011) begin n_fail++; $display("FAIL bp_hold_data[%0d]: got %h", i, bus.out_data); end
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      drive_beat(32'h21, 1'b0);
      drive_beat(32'h22, 1'b0);
      drive_beat(32'h23, 1'b0);
      drive_beat(32'h24, 1'b1);
      idle(3);
      n_cmp++;
      if (cap_data.size() != 2) begin
         n_fail++; $display("FAIL bp_count: got %0d beats want 2", cap_data.size());
      end else begin
         n_cmp++; if (cap_data[0] !== 128'h00000014_00000013_00000012_00000011) begin n_fail++; $display("FAIL bp_data0: got %h", cap_data[0]); end
         n_cmp++; if (cap_last[0] !== 1'b0) begin n_fail++; $display("FAIL bp_last0: got %b want 0", cap_last[0]); end
         n_cmp++; if (cap_data[1] !== 128'h00000024_00000023_00000022_00000021) begin n_fail++; $display("FAIL bp_data1: got %h", cap_data[1]); end
         n_cmp++; if (cap_keep[1] !== 4'hF) begin n_fail++; $display("FAIL bp_keep1: got %h want f", cap_keep[1]); end
         n_cmp++; if (cap_last[1] !== 1'b1) begin n_fail++; $display("FAIL bp_last1: got %b want 1", cap_last[1]); end
      end
   endtask

   task automatic test_back_to_back();
      clear_caps();
      bus.out_ready = 1'b1;
      drive_beat(32'h41, 1'b1);
      drive_beat(32'h42, 1'b1);
      drive_beat(32'h43, 1'b1);
      for (int i = 0; i < 8; i++) drive_beat(32'h51 + 32'(i), i == 7);
      idle(3);
      n_cmp++;
      if (cap_data.size() != 5) begin
         n_fail++; $display("FAIL b2b_count: got %0d beats want 5", cap_data.size());
      end else begin
         n_cmp++; if (cap_cyc[1] !== cap_cyc[0] + 1) begin n_fail++; $display("FAIL b2b_bubble01: cycles %0d,%0d want adjacent", cap_cyc[0], cap_cyc[1]); end
         n_cmp++; if (cap_cyc[2] !== cap_cyc[1] + 1) begin n_fail++; $display("FAIL b2b_bubble12: cycles %0d,%0d want adjacent", cap_cyc[1], cap_cyc[2]); end
         n_cmp++; if (cap_data[0] !== 128'h41) begin n_fail++; $display("FAIL b2b_data0: got %h want 41", cap_data[0]); end
         n_cmp++; if (cap_data[1] !== 128'h42) begin n_fail++; $display("FAIL b2b_data1: got %h want 42", cap_data[1]); end
         n_cmp++; if (cap_data[2] !== 128'h43) begin n_fail++; $display("FAIL b2b_data2: got %h want 43", cap_data[2]); end
         n_cmp++; if (cap_data[3] !== 128'h00000054_00000053_00000052_00000051) begin n_fail++; $display("FAIL b2b_data3: got %h", cap_data[3]); end
         n_cmp++; if (cap_data[4] !== 128'h00000058_00000057_00000056_00000055) begin n_fail++; $display("FAIL b2b_data4: got %h", cap_data[4]); end
         n_cmp++; if (cap_last[3] !== 1'b0 || cap_last[4] !== 1'b1) begin n_fail++; $display("FAIL b2b_last: got %b%b want 01", cap_last[3], cap_last[4]); end
      end
   endtask

   task automatic test_reset_mid();
      clear_caps();
      bus.out_ready = 1'b1;
      drive_beat(32'hE1, 1'b0);
      drive_beat(32'hE2, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid); end
      @(posedge clk); #1;
      for (int i = 1; i <= 4; i++) drive_beat(32'(i), 1'b0);
      idle(3);
      n_cmp++;
      if (cap_data.size() != 1) begin
         n_fail++; $display("FAIL rstmid_count: got %0d beats want 1", cap_data.size());
      end else begin
         n_cmp++; if (cap_data[0] !== 128'h00000004_00000003_00000002_00000001) begin n_fail++; $display("FAIL rstmid_data: got %h", cap_data[0]); end
         n_cmp++; if (cap_keep[0] !== 4'hF) begin n_fail++; $display("FAIL rstmid_keep: got %h want f", cap_keep[0]); end
      end
   endtask

   initial begin
      test_reset();
      test_full_words();
      test_short_packet();
      test_single_beat();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end
endmodule
